// File: rtl/simple_pipe_inst_queue.sv
// Instruction queue between fetch and decode/execute, DEPTH entries.
// Define SIMPLE_PIPE_INST_QUEUE_BYPASS_EN for same-cycle empty-queue bypass.
module simple_pipe_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_inst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_inst,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_is_and,
    output logic [4:0] count,
    output logic [7:0] stall_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic [7:0]    r_stall;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == 5'(DEPTH));
    assign w_empty = (r_count == 5'd0);

`ifdef SIMPLE_PIPE_INST_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && in_valid && out_ready && !flush && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = !rst && !w_full && !flush;
    // A bypassed instruction goes straight out and is never stored.
    assign w_push    = in_valid && in_ready && !w_bypass;
    assign w_pop     = !w_empty && out_ready && !flush;

    assign out_valid  = !w_empty || w_bypass;
    assign out_inst   = w_bypass ? in_inst :
                        (!w_empty ? r_mem[r_rptr] : 8'h00);
    assign out_is_and = out_valid && (out_inst[7:6] == 2'b11);
    assign count      = r_count;
    assign stall_cnt  = r_stall;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Back-pressure counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= 8'd0;
        end else if (out_valid && !out_ready && !flush && (r_stall != 8'hFF)) begin
            r_stall <= r_stall + 8'd1;
        end
    end
endmodule
